// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between fetch, read-stage
// and write-stage requesters with fixed priority write > read > fetch.
// One bus transaction in flight at a time; read data returns with a one-cycle
// valid pulse to the owner.
// Optional feature macro: MEM_BUS_ARBITER_LOCK_EN enables bus locking so a
// locked load (r_lock) is followed atomically by the write stage's store.
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_address,
    output logic [DW-1:0] f_data,
    output logic          f_valid,
    input  logic          r_req,
    input  logic [AW-1:0] r_address,
    input  logic          r_lock,
    output logic [DW-1:0] r_data,
    output logic          r_valid,
    input  logic          w_req,
    input  logic [AW-1:0] w_address,
    input  logic [DW-1:0] w_data,
    output logic          w_valid,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_writedata,
    input  logic [DW-1:0] mem_readdata,
    input  logic          mem_waitrequest,
    input  logic          mem_readdatavalid,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, LOCKED} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_F    = 2'd1;
    localparam logic [1:0] OWN_R    = 2'd2;
    localparam logic [1:0] OWN_W    = 2'd3;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          lock_q, lock_d;
    logic          flush_q, flush_d;
    logic [DW-1:0] f_data_q, f_data_d;
    logic [DW-1:0] r_data_q, r_data_d;
    logic          f_valid_q, f_valid_d;
    logic          r_valid_q, r_valid_d;
    logic          w_valid_q, w_valid_d;

    logic          lock_req;
    logic          owner_req;
    logic          w_elig, r_elig, f_elig;

`ifdef MEM_BUS_ARBITER_LOCK_EN
    assign lock_req = r_lock;
`else
    // Lock input is deliberately ignored in this build.
    logic unused_r_lock;
    assign unused_r_lock = r_lock;
    assign lock_req      = 1'b0;
`endif

    // A requester whose valid pulses this cycle still holds its old req;
    // masking it keeps the stale request from being granted again.
    assign w_elig = w_req & ~w_valid_q;
    assign r_elig = r_req & ~r_valid_q;
    assign f_elig = f_req & ~f_valid_q;

    // Current owner's request line, used to detect a flush mid-transaction.
    always_comb begin
        owner_req = 1'b0;
        case (owner_q)
            OWN_F:   owner_req = f_req;
            OWN_R:   owner_req = r_req;
            OWN_W:   owner_req = w_req;
            default: owner_req = 1'b0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            lock_q    <= 1'b0;
            flush_q   <= 1'b0;
            f_data_q  <= '0;
            r_data_q  <= '0;
            f_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            w_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lock_q    <= lock_d;
            flush_q   <= flush_d;
            f_data_q  <= f_data_d;
            r_data_q  <= r_data_d;
            f_valid_q <= f_valid_d;
            r_valid_q <= r_valid_d;
            w_valid_q <= w_valid_d;
        end
    end

    // Next-state: arbitration, bus handshake tracking and completion pulses.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lock_d    = lock_q;
        f_data_d  = f_data_q;
        r_data_d  = r_data_q;
        f_valid_d = 1'b0;
        r_valid_d = 1'b0;
        w_valid_d = 1'b0;
        // Once the owner lets go, the transaction finishes silently.
        flush_d   = flush_q |
                    (((state_q == ISSUE) || (state_q == WAIT_DATA)) & ~owner_req);
        case (state_q)
            IDLE: begin
                if (w_elig) begin
                    owner_d = OWN_W;
                    addr_d  = w_address;
                    wdata_d = w_data;
                    lock_d  = 1'b0;
                    flush_d = 1'b0;
                    state_d = ISSUE;
                end else if (r_elig) begin
                    owner_d = OWN_R;
                    addr_d  = r_address;
                    lock_d  = lock_req;
                    flush_d = 1'b0;
                    state_d = ISSUE;
                end else if (f_elig) begin
                    owner_d = OWN_F;
                    addr_d  = f_address;
                    lock_d  = 1'b0;
                    flush_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_waitrequest) begin
                    if (owner_q == OWN_W) begin
                        w_valid_d = ~flush_d;
                        state_d   = lock_q ? LOCKED : IDLE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (mem_readdatavalid) begin
                    if (!flush_d) begin
                        if (owner_q == OWN_F) begin
                            f_data_d  = mem_readdata;
                            f_valid_d = 1'b1;
                        end else begin
                            r_data_d  = mem_readdata;
                            r_valid_d = 1'b1;
                        end
                    end
                    state_d = lock_q ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                // Only the store completing the atomic pair may use the bus.
                if (w_elig) begin
                    owner_d = OWN_W;
                    addr_d  = w_address;
                    wdata_d = w_data;
                    flush_d = 1'b0;
                    state_d = ISSUE;
                end else if (!lock_req) begin
                    lock_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus command and grant outputs decoded from the registered state.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        grant     = OWN_NONE;
        if (state_q == ISSUE) begin
            mem_read  = (owner_q != OWN_W);
            mem_write = (owner_q == OWN_W);
        end
        if ((state_q == ISSUE) || (state_q == WAIT_DATA)) begin
            grant = owner_q;
        end
    end

    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign f_data        = f_data_q;
    assign r_data        = r_data_q;
    assign f_valid       = f_valid_q;
    assign r_valid       = r_valid_q;
    assign w_valid       = w_valid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected bus commands
// and valid pulses into a queue; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int K_RD = 0, K_WR = 1, K_FV = 2, K_RV = 3, K_WV = 4;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  g;
        int          cyc;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        f_req = 1'b0, r_req = 1'b0, w_req = 1'b0, r_lock = 1'b0;
    logic [31:0] f_address = '0, r_address = '0, w_address = '0, w_data = '0;
    logic [31:0] f_data, r_data, mem_address, mem_writedata;
    logic [31:0] mem_readdata;
    logic        f_valid, r_valid, w_valid, mem_read, mem_write;
    logic        mem_waitrequest, mem_readdatavalid;
    logic [1:0]  grant;

    int tests = 0, fails = 0, cyc = 0;
    int stall_cycles = 0, rd_delay = 1;
    ev_t exp_q[$];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    mem_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .f_req(f_req), .f_address(f_address), .f_data(f_data), .f_valid(f_valid),
        .r_req(r_req), .r_address(r_address), .r_lock(r_lock), .r_data(r_data),
        .r_valid(r_valid),
        .w_req(w_req), .w_address(w_address), .w_data(w_data), .w_valid(w_valid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
        .grant(grant)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Reference memory: last store to an address, else the default pattern.
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic vld(input int who);
        case (who)
            0:       return f_valid;
            1:       return r_valid;
            default: return w_valid;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] g, input int c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.g = g; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        logic bad;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event kind=%0d addr=%h data=%h cyc=%0d, required none",
                     k, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            bad = (e.kind != k) || (e.g != grant);
            if ((k == K_RD || k == K_WR) && e.addr != a) bad = 1'b1;
            if ((k == K_WR || k == K_FV || k == K_RV) && e.data != d) bad = 1'b1;
            if (e.cyc >= 0 && e.cyc != cyc) bad = 1'b1;
            if (bad) begin
                fails++;
                $display("FAIL event actual kind=%0d addr=%h data=%h grant=%0d cyc=%0d required kind=%0d addr=%h data=%h grant=%0d cyc=%0d",
                         k, a, d, grant, cyc, e.kind, e.addr, e.data, e.g, e.cyc);
            end
        end
    endtask

    // Bus slave model: programmable stall, read latency counted from acceptance.
    initial begin : responder
        int stall_cnt, rd_cnt;
        logic [31:0] rd_val;
        stall_cnt = 0; rd_cnt = 0; rd_val = '0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
        forever begin
            @(posedge clock); #1;
            mem_readdatavalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = rd_val;
                end
            end
            if (mem_read || mem_write) begin
                if (stall_cnt < stall_cycles) begin
                    mem_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mem_waitrequest = 1'b0;
                    stall_cnt = 0;
                    if (mem_write) bus_mem[mem_address] = mem_writedata;
                    else begin
                        rd_val = bus_mem.exists(mem_address) ? bus_mem[mem_address]
                                                             : dflt(mem_address);
                        rd_cnt = rd_delay;
                    end
                end
            end else begin
                mem_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Monitor: every accepted command and every valid pulse is scored.
    initial begin : monitor
        logic hv, hw;
        logic [31:0] ha, hd;
        hv = 1'b0; hw = 1'b0; ha = '0; hd = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) hv = 1'b0;
            else begin
                if (hv) chk("cmd_stable", {mem_read, mem_write, mem_address, mem_writedata},
                            {~hw, hw, ha, hd});
                hv = (mem_read || mem_write) && mem_waitrequest;
                hw = mem_write; ha = mem_address; hd = mem_writedata;
                if (mem_read && !mem_waitrequest)  check_ev(K_RD, mem_address, 32'h0);
                if (mem_write && !mem_waitrequest) check_ev(K_WR, mem_address, mem_writedata);
                if (f_valid) check_ev(K_FV, 32'h0, f_data);
                if (r_valid) check_ev(K_RV, 32'h0, r_data);
                if (w_valid) check_ev(K_WV, 32'h0, 32'h0);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin @(posedge clock); #1; end
    endtask

    // Raise a request, hold it until its valid pulse, then drop it.
    task automatic run_req(input int who, input logic [31:0] a, input logic [31:0] d,
                           input logic lk);
        int n;
        case (who)
            0: begin f_address = a; f_req = 1'b1; end
            1: begin r_address = a; r_lock = lk; r_req = 1'b1; end
            default: begin w_address = a; w_data = d; w_req = 1'b1; end
        endcase
        for (n = 0; n < 200; n++) begin
            @(negedge clock);
            if (vld(who)) break;
        end
        if (n == 200) begin
            tests++; fails++;
            $display("FAIL timeout requester=%0d addr=%h, required a valid pulse", who, a);
        end
        @(posedge clock); #1;
        case (who)
            0: f_req = 1'b0;
            1: r_req = 1'b0;
            default: w_req = 1'b0;
        endcase
    endtask

    initial begin : stim
        int n;
        logic [31:0] r_prev, v;
        step(2);
        chk("rst_f_data", f_data, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_bus", {mem_address, mem_writedata}, 0);
        chk("rst_ctl", {mem_read, mem_write, f_valid, r_valid, w_valid, grant}, 0);
        reset_n = 1'b1;
        step(1);

        // Single fetch, latency and no re-grant.
        bus_mem[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
        n = cyc;
        push(K_RD, 32'h100, 0, 2'd1, n + 1);
        push(K_FV, 0, 32'hDEADBEEF, 2'd0, n + 3);
        run_req(0, 32'h100, 0, 1'b0);
        chk("no_regrant", {mem_read, grant}, 0);
        step(2);

        // All three requesters at once: write, read, fetch.
        n = cyc;
        push(K_WR, 32'h20, 32'h55, 2'd3, n + 1);
        push(K_WV, 0, 0, 2'd0, n + 2);
        ref_mem[32'h20] = 32'h55;
        push(K_RD, 32'h40, 0, 2'd2, n + 3);
        push(K_RV, 0, ref_read(32'h40), 2'd0, n + 5);
        push(K_RD, 32'h60, 0, 2'd1, n + 6);
        push(K_FV, 0, ref_read(32'h60), 2'd0, n + 8);
        fork
            run_req(2, 32'h20, 32'h55, 1'b0);
            run_req(1, 32'h40, 0, 1'b0);
            run_req(0, 32'h60, 0, 1'b0);
        join
        step(2);

        // Stalled write held stable for four cycles.
        stall_cycles = 3;
        n = cyc;
        push(K_WR, 32'h80, 32'hCAFE0080, 2'd3, n + 4);
        push(K_WV, 0, 0, 2'd0, n + 5);
        ref_mem[32'h80] = 32'hCAFE0080;
        run_req(2, 32'h80, 32'hCAFE0080, 1'b0);
        stall_cycles = 0;
        step(2);

        // Locked load followed by store, with a fetch waiting.
        n = cyc;
        r_prev = ref_read(32'h10);
        push(K_RD, 32'h10, 0, 2'd2, n + 1);
        push(K_RV, 0, r_prev, 2'd0, n + 3);
`ifdef MEM_BUS_ARBITER_LOCK_EN
        push(K_WR, 32'h10, 32'h77, 2'd3, -1);
        push(K_WV, 0, 0, 2'd0, -1);
        push(K_RD, 32'h60, 0, 2'd1, -1);
        push(K_FV, 0, ref_read(32'h60), 2'd0, -1);
`else
        push(K_RD, 32'h60, 0, 2'd1, -1);
        push(K_FV, 0, ref_read(32'h60), 2'd0, -1);
        push(K_WR, 32'h10, 32'h77, 2'd3, -1);
        push(K_WV, 0, 0, 2'd0, -1);
`endif
        ref_mem[32'h10] = 32'h77;
        fork
            run_req(1, 32'h10, 0, 1'b1);
            run_req(0, 32'h60, 0, 1'b0);
            begin
                step(5);
                run_req(2, 32'h10, 32'h77, 1'b0);
                r_lock = 1'b0;
            end
        join
        step(3);

        // Flush: load dropped during WAIT_DATA.
        rd_delay = 3;
        n = cyc;
        push(K_RD, 32'h44, 0, 2'd2, n + 1);
        r_address = 32'h44; r_req = 1'b1;
        step(2);
        r_req = 1'b0;
        step(4);
        chk("flush_r_data_held", r_data, r_prev);
        chk("flush_idle", {grant, mem_read, mem_write}, 0);
        rd_delay = 1;
        n = cyc;
        push(K_RD, 32'h64, 0, 2'd1, n + 1);
        push(K_FV, 0, ref_read(32'h64), 2'd0, n + 3);
        run_req(0, 32'h64, 0, 1'b0);
        step(2);

        // Reset during WAIT_DATA, late data afterwards.
        rd_delay = 4;
        n = cyc;
        push(K_RD, 32'h300, 0, 2'd1, n + 1);
        f_address = 32'h300; f_req = 1'b1;
        step(2);
        reset_n = 1'b0; f_req = 1'b0;
        #1;
        chk("mid_rst_data", {f_data, r_data}, 0);
        chk("mid_rst_bus", {mem_address, mem_writedata}, 0);
        chk("mid_rst_ctl", {mem_read, mem_write, f_valid, r_valid, w_valid, grant}, 0);
        step(1);
        reset_n = 1'b1;
        step(4);
        chk("late_data_ignored", {f_data, r_data, f_valid, r_valid, grant}, 0);
        rd_delay = 1;
        step(1);

        // Randomized batches; simultaneous requests resolve write, read, fetch.
        for (int b = 0; b < 40; b++) begin
            logic [2:0] m;
            logic [31:0] wa, wd, ra, fa;
            stall_cycles = $urandom_range(0, 2);
            rd_delay = $urandom_range(1, 3);
            m = 3'($urandom_range(1, 7));
            wa = 32'($urandom_range(0, 15) * 4);
            ra = 32'($urandom_range(0, 15) * 4);
            fa = 32'($urandom_range(0, 15) * 4);
            wd = $urandom;
            if (m[2]) begin
                push(K_WR, wa, wd, 2'd3, -1);
                push(K_WV, 0, 0, 2'd0, -1);
                ref_mem[wa] = wd;
            end
            if (m[1]) begin
                v = ref_read(ra);
                push(K_RD, ra, 0, 2'd2, -1);
                push(K_RV, 0, v, 2'd0, -1);
            end
            if (m[0]) begin
                v = ref_read(fa);
                push(K_RD, fa, 0, 2'd1, -1);
                push(K_FV, 0, v, 2'd0, -1);
            end
            fork
                if (m[2]) run_req(2, wa, wd, 1'b0);
                if (m[1]) run_req(1, ra, 0, 1'b0);
                if (m[0]) run_req(0, fa, 0, 1'b0);
            join
            step(1);
        end

        step(10);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
